fma_retire_stage: RTL
=====================

# fma_retire_stage

Retirement stage of the single-precision fused multiply-add pipeline, directly downstream of the normalize-and-round stage. It captures each rounded result (sign, biased exponent, mantissa) and its exception flags into a 2-entry buffer with a valid/ready handshake. It presents the packed IEEE-754 word to the register-file writeback. It also maintains the sticky `fflags` accumulator, ORing in each operation's flags at retirement and honouring software CSR writes.

## Interface
- `PARM_EXP`, 8, exponent width
- `PARM_MANT`, 23, stored mantissa width (no hidden bit)
- `PARM_FLAGS`, 5, fflags width; bit order NV=4, DZ=3, OF=2, UF=1, NX=0

Ports:
- `clk_i`  in  1  sole clock, rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `Valid_i`  in  1  upstream result valid
- `Ready_o`  out  1  stage can accept this cycle
- `Sign_i`  in  1  result sign
- `Exp_i`  in  PARM_EXP  rounded biased exponent
- `Mant_i`  in  PARM_MANT  rounded mantissa
- `Invalid_i`, `Overflow_i`, `Underflow_i`, `Inexact_i`  in  1 each  per-op exception flags
- `Valid_o`  out  1  retiring result valid
- `Ready_i`  in  1  writeback accepts
- `Result_o`  out  1+PARM_EXP+PARM_MANT  packed {sign, exp, mant}
- `Fflags_o`  out  PARM_FLAGS  per-op flags of retiring result; DZ always 0
- `Flush_i`  in  1  discard all buffered, un-retired results
- `Csr_we_i`  in  1  software write of fflags
- `Csr_wdata_i`  in  PARM_FLAGS  write data
- `Fflags_acc_o`  out  PARM_FLAGS  sticky accumulated flags

## Operation
- Push when `Valid_i & Ready_o`. Pop when `Valid_o & Ready_i`. Strict FIFO order.
- Buffer holds 2 entries; occupancy counter `cnt` in 0..2.
- `Ready_o = (cnt != 2) & ~rst_i`, registered-state based. It has no combinational path from `Ready_i`.
- `Valid_o = (cnt != 0)`. `Result_o` and `Fflags_o` come from the head entry register.
  - When empty, outputs hold their last value.
  - After reset, outputs are 0.
- Simultaneous push and pop: `cnt` unchanged. The new entry goes behind the head, or becomes the head if `cnt` was 1.
- Accumulator update: `acc_next = (Csr_we_i ? Csr_wdata_i : acc) | (pop ? Fflags_o : 0)`.
  - A CSR write in the same cycle as a retirement keeps the retiring flags.
- `Flush_i` has priority over push and pop:
  - next `cnt` = 0.
  - A push in the same cycle is dropped.
  - A pop in the same cycle still counts: its flags are ORed into `acc`, and writeback has consumed it.
  - `acc` is otherwise unchanged.
- `Csr_we_i` is independent of `Flush_i`.
- No re-rounding or NaN canonicalisation; the upstream stage guarantees the fields.

## Timing
- Reset values:
  - `cnt` = 0, `Valid_o` = 0, `Result_o` = 0, `Fflags_o` = 0, `Fflags_acc_o` = 0.
  - `Ready_o` = 0 while `rst_i` is high, and 1 in the first cycle after release.
- Latency: push in cycle N → `Valid_o` in N+1 when the buffer was empty, or when `cnt` was 1 with a pop in N.
- Throughput: 1 op/cycle sustained with `Ready_i` held high.
- Full: `Ready_o` falls in the cycle after the second push without a pop. It rises in the cycle after the first pop.
- `Fflags_acc_o` reflects a retirement or CSR write in cycle N+1.
- A reset assertion mid-operation clears everything asynchronously. In-flight entries are lost.

## Structure
- Shared package `fma_pkg`:
  - `PARM_EXP`, `PARM_MANT`, `PARM_FLAGS`.
  - Flag bit index constants `FLAG_NV`, `FLAG_DZ`, `FLAG_OF`, `FLAG_UF`, `FLAG_NX`.
  - Rounding-mode encodings RNE/RTZ/RDN/RUP/RMM = 0..4.
  - Canonical NaN mantissa `PARM_MANT_NAN`.
  - Packed entry typedef {sign, exp, mant, flags}.
- One sub-module: `fma_skid_fifo`, a generic 2-entry valid/ready buffer, parameterised by payload width, with a flush input.
- Flag accumulation and packing live in the top.

## Test plan
- Reset, then release → all outputs 0. `Ready_o`=1 one cycle after release. `Valid_o`=0.
- Single push of Sign=0, Exp=8'h7F, Mant=0, Inexact=1 with `Ready_i`=1 → next cycle `Valid_o`=1, `Result_o`=32'h3F80_0000, `Fflags_o`=5'b00001. The cycle after, `Fflags_acc_o`=5'b00001.
- `Ready_i`=0 while pushing ops A, B, C back-to-back → A and B accepted, `Ready_o`=0 and C held. Raising `Ready_i` → A, B, C retire in order on consecutive cycles.
- Start with `acc`=5'b00001. Apply `Csr_we_i`=1, `Csr_wdata_i`=0 in the same cycle as retiring an op with Overflow+Inexact → `Fflags_acc_o`=5'b00101.
- With 2 entries buffered and `Ready_i`=0, pulse `Flush_i` → next cycle `Valid_o`=0, `Ready_o`=1, `acc` unchanged, and the flushed entries never appear.
- Push Result 32'h7FC0_0000 with Invalid=1 → `Fflags_o`=5'b10000. `Fflags_acc_o` bit 4 sets after retirement, and DZ stays 0.

Source files
------------

// File: rtl/fma_pkg.sv
// Shared FMA pipeline constants, rounding-mode encodings and the retire-buffer entry type.
package fma_pkg;

   localparam int unsigned PARM_EXP   = 8;
   localparam int unsigned PARM_MANT  = 23;
   localparam int unsigned PARM_FLAGS = 5;
   localparam int unsigned RESULT_W   = 1 + PARM_EXP + PARM_MANT;

   localparam int unsigned FLAG_NV = 4;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } rnd_mode_e;

   // Quiet-NaN mantissa: only the top mantissa bit set
   localparam logic [PARM_MANT-1:0] PARM_MANT_NAN = {1'b1, {(PARM_MANT-1){1'b0}}};

   typedef struct packed {
      logic                  sign;
      logic [PARM_EXP-1:0]   exp;
      logic [PARM_MANT-1:0]  mant;
      logic [PARM_FLAGS-1:0] flags;
   } fma_entry_t;

   localparam int unsigned ENTRY_W = $bits(fma_entry_t);

endpackage

// File: rtl/fma_skid_fifo.sv
// Generic 2-entry valid/ready buffer with flush; head output holds its last value when empty.
module fma_skid_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   input  logic             flush_i
);

   localparam logic [1:0] CNT_EMPTY = 2'd0;
   localparam logic [1:0] CNT_ONE   = 2'd1;
   localparam logic [1:0] CNT_FULL  = 2'd2;

   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             push, pop;

   assign ready_o = (cnt_q != CNT_FULL) & ~rst_i;
   assign valid_o = (cnt_q != CNT_EMPTY);
   assign data_o  = head_q;

   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      push   = valid_i & ready_o;
      pop    = valid_o & ready_i;
      // Flush drops any push; the head register is kept so outputs hold
      if (flush_i) begin
         cnt_d = CNT_EMPTY;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt_q == CNT_EMPTY) head_d = data_i;
               else                    tail_d = data_i;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               if (cnt_q == CNT_FULL) head_d = tail_q;
               cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == CNT_ONE) begin
                  head_d = data_i;
               end else begin
                  head_d = tail_q;
                  tail_d = data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= CNT_EMPTY;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

endmodule

// File: rtl/fma_retire_stage.sv
// FMA retirement stage: buffers rounded results, presents packed IEEE-754 words
// to writeback and keeps the sticky fflags accumulator.
module fma_retire_stage
   import fma_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  Valid_i,
   output logic                  Ready_o,
   input  logic                  Sign_i,
   input  logic [PARM_EXP-1:0]   Exp_i,
   input  logic [PARM_MANT-1:0]  Mant_i,
   input  logic                  Invalid_i,
   input  logic                  Overflow_i,
   input  logic                  Underflow_i,
   input  logic                  Inexact_i,
   output logic                  Valid_o,
   input  logic                  Ready_i,
   output logic [RESULT_W-1:0]   Result_o,
   output logic [PARM_FLAGS-1:0] Fflags_o,
   input  logic                  Flush_i,
   input  logic                  Csr_we_i,
   input  logic [PARM_FLAGS-1:0] Csr_wdata_i,
   output logic [PARM_FLAGS-1:0] Fflags_acc_o
);

   fma_entry_t            in_entry;
   fma_entry_t            head_entry;
   logic [ENTRY_W-1:0]    head_bits;
   logic [PARM_FLAGS-1:0] acc_q, acc_d;
   logic                  pop;

   // An FMA can never divide by zero, so DZ is tied low at capture
   always_comb begin
      in_entry                = '0;
      in_entry.sign           = Sign_i;
      in_entry.exp            = Exp_i;
      in_entry.mant           = Mant_i;
      in_entry.flags[FLAG_NV] = Invalid_i;
      in_entry.flags[FLAG_DZ] = 1'b0;
      in_entry.flags[FLAG_OF] = Overflow_i;
      in_entry.flags[FLAG_UF] = Underflow_i;
      in_entry.flags[FLAG_NX] = Inexact_i;
   end

   fma_skid_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (Valid_i),
      .ready_o (Ready_o),
      .data_i  (in_entry),
      .valid_o (Valid_o),
      .ready_i (Ready_i),
      .data_o  (head_bits),
      .flush_i (Flush_i)
   );

   assign head_entry = fma_entry_t'(head_bits);
   assign Result_o   = {head_entry.sign, head_entry.exp, head_entry.mant};
   assign Fflags_o   = head_entry.flags;
   assign pop        = Valid_o & Ready_i;

   // A retirement coinciding with a flush or CSR write still contributes its flags
   always_comb begin
      acc_d = acc_q;
      if (Csr_we_i) acc_d = Csr_wdata_i;
      if (pop)      acc_d = acc_d | Fflags_o;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign Fflags_acc_o = acc_q;

endmodule
